// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: divide-request op codes shared by the Execute stage and the divide controller.
`default_nettype none

package div_ctrl_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: Execute-stage request, divider handshake and HI/LO result bundle of div_ctrl.
`default_nettype none

interface div_ctrl_if;

  logic [7:0]  alucontrolE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        flushE;
  logic        ready_i;
  logic [63:0] result_i;

  logic        start_o;
  logic        signed_o;
  logic        annul_o;
  logic [31:0] opdata1_o;
  logic [31:0] opdata2_o;
  logic        stall_div;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        timeout_err;

  modport master (
    output alucontrolE, SrcAE, SrcBE, flushE, ready_i, result_i,
    input  start_o, signed_o, annul_o, opdata1_o, opdata2_o,
    input  stall_div, result_valid, hi_out, lo_out, timeout_err
  );

  modport slave (
    input  alucontrolE, SrcAE, SrcBE, flushE, ready_i, result_i,
    output start_o, signed_o, annul_o, opdata1_o, opdata2_o,
    output stall_div, result_valid, hi_out, lo_out, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
// div_ctrl: sequences a multi-cycle divide from the Execute stage, stalls the pipeline
// and delivers remainder/quotient for the HI/LO write, with flush and timeout aborts.
`default_nettype none

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  wire logic   clka,
  input  wire logic   rst,
  div_ctrl_if.slave   bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] busy_cnt;
  logic          req;
  logic          timeout_hit;
  logic          start, annul, stall, res_valid;

  logic          signed_q;
  logic [31:0]   op1_q, op2_q, hi_q, lo_q;
  logic          err_q;

  always_comb begin
    req         = is_div_op(bus.alucontrolE) & ~bus.flushE;
    // busy_cnt counts completed BUSY cycles, so this fires after TIMEOUT full waits
    timeout_hit = (busy_cnt == CW'(TIMEOUT)) & ~bus.ready_i;
    state_nxt   = state;
    start       = 1'b0;
    annul       = 1'b0;
    stall       = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = (bus.SrcBE != 32'd0) ? BUSY : DONE;
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.flushE) begin
          annul     = 1'b1;
          state_nxt = IDLE;
        end else if (bus.ready_i) begin
          start     = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          annul     = 1'b1;
          state_nxt = DONE;
        end else begin
          start = 1'b1;
        end
      end
      DONE: begin
        res_valid = ~bus.flushE;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      start     = 1'b0;
      annul     = 1'b0;
      stall     = 1'b0;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state    <= IDLE;
      busy_cnt <= '0;
      signed_q <= 1'b0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            if (bus.SrcBE != 32'd0) begin
              op1_q    <= bus.SrcAE;
              op2_q    <= bus.SrcBE;
              signed_q <= (bus.alucontrolE == EXE_DIV_OP);
              busy_cnt <= '0;
            end else begin
              // divide by zero bypasses the divider entirely
              hi_q <= bus.SrcAE;
              lo_q <= 32'hFFFF_FFFF;
            end
          end
        end
        BUSY: begin
          busy_cnt <= busy_cnt + CW'(1);
          if (!bus.flushE) begin
            if (bus.ready_i) begin
              hi_q <= bus.result_i[63:32];
              lo_q <= bus.result_i[31:0];
            end else if (timeout_hit) begin
              hi_q  <= 32'd0;
              lo_q  <= 32'd0;
              err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_o      = start;
  assign bus.annul_o      = annul;
  assign bus.stall_div    = stall;
  assign bus.result_valid = res_valid;
  assign bus.signed_o     = signed_q;
  assign bus.opdata1_o    = op1_q;
  assign bus.opdata2_o    = op2_q;
  assign bus.hi_out       = hi_q;
  assign bus.lo_out       = lo_q;
  assign bus.timeout_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl.
`default_nettype none

module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clka;
  logic rst;
  int   n_checks;
  int   n_errors;

  div_ctrl_if bus();

  div_ctrl #(.TIMEOUT(40)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int ready_at, input logic [63:0] res,
                         output int stalls, output int starts, output int annuls,
                         output int rv_cyc);
    int busy;
    bit seen;
    bus.alucontrolE = op;
    bus.SrcAE       = a;
    bus.SrcBE       = b;
    bus.flushE      = 1'b0;
    bus.ready_i     = 1'b0;
    bus.result_i    = res;
    stalls = 0; starts = 0; annuls = 0; rv_cyc = -1; busy = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clka);
      if (bus.start_o) begin
        busy++;
        bus.ready_i = (busy == ready_at);
      end
      #1;
      check("excl", {63'd0, (bus.start_o & bus.annul_o) | (bus.start_o & bus.result_valid) |
                            (bus.annul_o & bus.result_valid)}, 64'd0);
      if (bus.stall_div)    stalls++;
      if (bus.start_o)      starts++;
      if (bus.annul_o)      annuls++;
      if (bus.result_valid) begin rv_cyc = c; seen = 1; end
    end
    check("rv_seen", {63'd0, seen}, 64'd1);
    @(posedge clka); #1;
    bus.alucontrolE = 8'h00;
    bus.ready_i     = 1'b0;
  endtask

  initial begin
    int st, sa, an, rc, busy;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.alucontrolE = EXE_DIV_OP;
    bus.SrcAE = 32'd11; bus.SrcBE = 32'd3;
    bus.flushE = 1'b0; bus.ready_i = 1'b0; bus.result_i = 64'd0;
    @(posedge clka); @(posedge clka);
    @(negedge clka);
    check("rst_stall", {63'd0, bus.stall_div}, 64'd0);
    check("rst_start", {63'd0, bus.start_o}, 64'd0);
    check("rst_hi",    {32'd0, bus.hi_out}, 64'd0);
    check("rst_lo",    {32'd0, bus.lo_out}, 64'd0);
    check("rst_err",   {63'd0, bus.timeout_err}, 64'd0);
    @(posedge clka); #1;
    rst = 1'b0;
    bus.alucontrolE = 8'h00;
    @(negedge clka);
    check("idle_stall", {63'd0, bus.stall_div}, 64'd0);
    @(posedge clka); #1;

    // DIVU 100/7, ready on the 32nd BUSY cycle
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32, {32'd2, 32'd14}, st, sa, an, rc);
    check("u_stall",  64'(st), 64'd33);
    check("u_starts", 64'(sa), 64'd32);
    check("u_rvcyc",  64'(rc), 64'd33);
    check("u_hi",     {32'd0, bus.hi_out}, 64'd2);
    check("u_lo",     {32'd0, bus.lo_out}, 64'd14);
    check("u_sgn",    {63'd0, bus.signed_o}, 64'd0);
    check("u_op1",    {32'd0, bus.opdata1_o}, 64'd100);
    check("u_op2",    {32'd0, bus.opdata2_o}, 64'd7);
    @(negedge clka);
    check("u_rv_once", {63'd0, bus.result_valid}, 64'd0);
    @(posedge clka); #1;

    // DIV -7/2 = -3 rem -1
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, st, sa, an, rc);
    check("s_stall", 64'(st), 64'd6);
    check("s_lo",    {32'd0, bus.lo_out}, 64'h0000_0000_FFFF_FFFD);
    check("s_hi",    {32'd0, bus.hi_out}, 64'h0000_0000_FFFF_FFFF);
    check("s_sgn",   {63'd0, bus.signed_o}, 64'd1);

    // DIV 5/0 bypasses the divider
    run_div(EXE_DIV_OP, 32'd5, 32'd0, 1, 64'd0, st, sa, an, rc);
    check("z_starts", 64'(sa), 64'd0);
    check("z_stall",  64'(st), 64'd1);
    check("z_rvcyc",  64'(rc), 64'd1);
    check("z_hi",     {32'd0, bus.hi_out}, 64'd5);
    check("z_lo",     {32'd0, bus.lo_out}, 64'h0000_0000_FFFF_FFFF);

    // flush in BUSY cycle 10
    bus.alucontrolE = EXE_DIVU_OP; bus.SrcAE = 32'd50; bus.SrcBE = 32'd6;
    busy = 0;
    for (int c = 0; c < 40 && busy < 10; c++) begin
      @(negedge clka);
      if (bus.start_o) busy++;
    end
    check("f_busy", 64'(busy), 64'd10);
    bus.flushE = 1'b1;
    #1;
    check("f_annul", {63'd0, bus.annul_o}, 64'd1);
    check("f_start", {63'd0, bus.start_o}, 64'd0);
    check("f_rv",    {63'd0, bus.result_valid}, 64'd0);
    @(posedge clka); #1;
    bus.flushE = 1'b0;
    bus.alucontrolE = 8'h00;
    @(negedge clka);
    check("f_idle_stall", {63'd0, bus.stall_div}, 64'd0);
    check("f_idle_rv",    {63'd0, bus.result_valid}, 64'd0);
    check("f_idle_annul", {63'd0, bus.annul_o}, 64'd0);
    check("f_hi", {32'd0, bus.hi_out}, 64'd5);
    check("f_lo", {32'd0, bus.lo_out}, 64'h0000_0000_FFFF_FFFF);
    @(posedge clka); #1;

    // timeout: ready_i never arrives
    run_div(EXE_DIVU_OP, 32'd8, 32'd2, 0, 64'd0, st, sa, an, rc);
    check("t_starts", 64'(sa), 64'd40);
    check("t_annuls", 64'(an), 64'd1);
    check("t_rvcyc",  64'(rc), 64'd42);
    check("t_hi",     {32'd0, bus.hi_out}, 64'd0);
    check("t_lo",     {32'd0, bus.lo_out}, 64'd0);
    check("t_err",    {63'd0, bus.timeout_err}, 64'd1);

    // back-to-back DIVU 9/3 then 10/4
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, 3, {32'd0, 32'd3}, st, sa, an, rc);
    check("b1_lo", {32'd0, bus.lo_out}, 64'd3);
    run_div(EXE_DIVU_OP, 32'd10, 32'd4, 4, {32'd2, 32'd2}, st, sa, an, rc);
    check("b2_stall", 64'(st), 64'd5);
    check("b2_lo",    {32'd0, bus.lo_out}, 64'd2);
    check("b2_hi",    {32'd0, bus.hi_out}, 64'd2);
    check("b2_err",   {63'd0, bus.timeout_err}, 64'd1);

    // reset in the middle of BUSY
    bus.alucontrolE = EXE_DIV_OP; bus.SrcAE = 32'd7; bus.SrcBE = 32'd7;
    busy = 0;
    for (int c = 0; c < 40 && busy < 5; c++) begin
      @(negedge clka);
      if (bus.start_o) busy++;
    end
    check("r_busy", 64'(busy), 64'd5);
    rst = 1'b1;
    #1;
    check("r_start", {63'd0, bus.start_o}, 64'd0);
    check("r_stall", {63'd0, bus.stall_div}, 64'd0);
    check("r_annul", {63'd0, bus.annul_o}, 64'd0);
    @(negedge clka);
    check("r_hi",  {32'd0, bus.hi_out}, 64'd0);
    check("r_lo",  {32'd0, bus.lo_out}, 64'd0);
    check("r_err", {63'd0, bus.timeout_err}, 64'd0);
    check("r_sgn", {63'd0, bus.signed_o}, 64'd0);
    check("r_op1", {32'd0, bus.opdata1_o}, 64'd0);
    check("r_rv",  {63'd0, bus.result_valid}, 64'd0);
    @(posedge clka); #1;
    rst = 1'b0;
    bus.alucontrolE = 8'h00;
    @(negedge clka);
    check("r_idle_start", {63'd0, bus.start_o}, 64'd0);
    check("r_idle_stall", {63'd0, bus.stall_div}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: max BUSY cycles waited for ready_i before forced abort.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clka  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 alucontrolE  input  8  Execute-stage ALU op code; EXE_DIV_OP / EXE_DIVU_OP mark a divide request.
REQ-005 SrcAE  input  32  dividend from Execute forwarding mux.
REQ-006 SrcBE  input  32  divisor from Execute forwarding mux.
REQ-007 flushE  input  1  Execute-stage flush; kills the in-flight divide.
REQ-008 ready_i  input  1  divider completion strobe.
REQ-009 result_i  input  64  divider result: [63:32] remainder, [31:0] quotient.
REQ-010 start_o  output  1  divider start, held high for the whole operation.
REQ-011 signed_o  output  1  1 = signed divide, registered at launch.
REQ-012 annul_o  output  1  one-cycle divider abort.
REQ-013 opdata1_o / opdata2_o  output  32 each  operands latched at launch.
REQ-014 stall_div  output  1  stalls F/D/E and bubbles M while a divide is pending.
REQ-015 result_valid  output  1  one-cycle strobe: hi_out/lo_out are valid for the HI/LO write.
REQ-016 hi_out / lo_out  output  32 each  remainder / quotient registers.
REQ-017 timeout_err  output  1  sticky error flag.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE.
REQ-019 IDLE: req = (alucontrolE is DIV or DIVU) & ~flushE.
- stall_div = req, combinational, in the same cycle.
REQ-020 IDLE, req, SrcBE != 0: at the clock edge, latch operands and signed_o, then go to BUSY.
REQ-021 IDLE, req, SrcBE == 0: skip the divider and go to DONE with hi_out = SrcAE, lo_out = 32'hFFFFFFFF.
- Latency is 1 cycle.
REQ-022 BUSY: start_o = 1 and stall_div = 1.
- A BUSY cycle counter increments each cycle.
REQ-023 BUSY with ready_i: latch hi_out = result_i[63:32], lo_out = result_i[31:0], then go to DONE.
REQ-024 BUSY with flushE, which has priority over ready_i: annul_o = 1 for that cycle, start_o = 0.
- Go to IDLE; hi_out/lo_out unchanged; no result_valid.
REQ-025 BUSY with counter reaching TIMEOUT and no ready_i: annul_o = 1, set timeout_err, go to DONE.
- lo_out = hi_out = 0.
REQ-026 DONE: stall_div = 0, result_valid = ~flushE, start_o = 0; next state is always IDLE.
- The divide instruction leaves E at this edge, so it is never relaunched.
REQ-027 Back-to-back divides: a DIV arriving in the IDLE cycle after DONE SHALL launch normally.
- No lost or duplicated operation.
REQ-028 Total stall for a nonzero divisor SHALL be k+1 cycles, where k is the number of BUSY cycles until ready_i.
REQ-029 start_o, annul_o and result_valid SHALL never be high in the same cycle.

Reset
REQ-030 rst SHALL force IDLE and clear counter, signed_o, operands, hi_out, lo_out and timeout_err.
- start_o, annul_o, stall_div and result_valid SHALL read 0 while rst is high.
REQ-031 rst asserted in BUSY SHALL abort without asserting annul_o.
- The divider is reset by the same rst.
REQ-032 timeout_err SHALL clear only on rst.

Structure
REQ-033 EXE_DIV_OP / EXE_DIVU_OP SHALL come from the shared defines.vh; state encodings stay local to div_ctrl.
REQ-034 Single module, no sub-modules; the existing divider is instantiated beside it in datapath.
- stall_div is OR-ed into the hazard unit's stall outputs.

Verification
REQ-035 DIVU 100/7, ready after 32 cycles -> hi_out = 2, lo_out = 14, result_valid for exactly 1 cycle, stall_div high 33 cycles.
REQ-036 DIV 0xFFFFFFF9 / 2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF, signed_o = 1.
REQ-037 DIV 5/0 -> no start_o, DONE next cycle, hi_out = 5, lo_out = 0xFFFFFFFF.
REQ-038 flushE in BUSY cycle 10 -> annul_o pulse, IDLE next cycle, hi_out/lo_out unchanged, no result_valid.
REQ-039 ready_i held low with TIMEOUT = 40 -> annul_o after 40 BUSY cycles, timeout_err = 1 until rst.
REQ-040 Two consecutive DIVU 9/3 then 10/4 -> lo_out sequence 3, 2; rst mid-BUSY -> all outputs 0 next cycle.
